// File: rtl/ins_mem_loader_if.sv
// Stream and BRAM port-B bundle for the instruction-memory preload engine.
// The master side belongs to the loader: it consumes the stream and drives the BRAM.
interface ins_mem_loader_if #(
  parameter int ADDR_W = 32
);
  logic [31:0]       s_data;
  logic              s_valid;
  logic              s_ready;
  logic              bram_enb;
  logic [3:0]        bram_web;
  logic [ADDR_W-1:0] bram_addrb;
  logic [31:0]       bram_dinb;
  logic [31:0]       bram_doutb;
  logic              bram_busy;

  modport master (
    input  s_data, s_valid, bram_doutb, bram_busy,
    output s_ready, bram_enb, bram_web, bram_addrb, bram_dinb
  );

  modport slave (
    output s_data, s_valid, bram_doutb, bram_busy,
    input  s_ready, bram_enb, bram_web, bram_addrb, bram_dinb
  );
endinterface

// File: rtl/ins_mem_loader.sv
// Preloads a word stream into instruction BRAM port B, then reads the region back
// and compares additive checksums; core_hold keeps the core stopped until verified.
module ins_mem_loader #(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              tb_clk,
  input  logic              rstb,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  ins_mem_loader_if.master  bus,
  output logic              load_done,
  output logic              load_error,
  output logic [CNT_W-1:0]  words_written,
  output logic [31:0]       checksum,
  output logic              core_hold
);

  typedef enum logic [2:0] {IDLE, LOAD, VERIFY, CHECK, DONE, ERROR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              rd_vld_q, rd_vld_d;
  logic [31:0]       rd_sum_q, rd_sum_d;
  logic [31:0]       wr_sum_q, wr_sum_d;
  logic              enb_q, enb_d;
  logic [3:0]        web_q, web_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              hold_q, hold_d;
  logic              s_ready_c;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [CNT_W-1:0]  idx);
    return base + (ADDR_W'(idx) << 2);
  endfunction

  // NOTE: every always_comb target gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    count_d   = count_q;
    wr_cnt_d  = wr_cnt_q;
    rd_idx_d  = rd_idx_q;
    rd_cnt_d  = rd_cnt_q;
    rd_sum_d  = rd_sum_q;
    wr_sum_d  = wr_sum_q;
    enb_d     = 1'b0;
    web_d     = 4'h0;
    addr_d    = addr_q;
    din_d     = din_q;
    done_d    = done_q;
    err_d     = err_q;
    hold_d    = hold_q;
    s_ready_c = 1'b0;
    // A read is on the bus this cycle, so its data appears on bram_doutb next cycle.
    rd_vld_d  = enb_q && (web_q == 4'h0);

    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (state_q == DONE) begin
          done_d = 1'b1;
          hold_d = 1'b0;
        end
        if (state_q == ERROR) begin
          err_d  = 1'b1;
          hold_d = 1'b1;
        end
        if (start) begin
          base_d   = base_addr & ~ADDR_W'(3);
          count_d  = word_count;
          wr_cnt_d = '0;
          rd_idx_d = '0;
          rd_cnt_d = '0;
          rd_sum_d = '0;
          wr_sum_d = '0;
          done_d   = 1'b0;
          err_d    = 1'b0;
          hold_d   = 1'b1;
          state_d  = (word_count == '0) ? DONE : LOAD;
        end
      end

      LOAD: begin
        s_ready_c = !bus.bram_busy && (wr_cnt_q < count_q);
        if (bus.s_valid && s_ready_c) begin
          enb_d    = 1'b1;
          web_d    = 4'hF;
          addr_d   = word_addr(base_q, wr_cnt_q);
          din_d    = bus.s_data;
          wr_sum_d = wr_sum_q + bus.s_data;
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_d == count_q) state_d = VERIFY;
        end
      end

      VERIFY: begin
        if (!bus.bram_busy && (rd_idx_q < count_q)) begin
          enb_d    = 1'b1;
          addr_d   = word_addr(base_q, rd_idx_q);
          rd_idx_d = rd_idx_q + 1'b1;
        end
        if (rd_vld_q) begin
          rd_sum_d = rd_sum_q + bus.bram_doutb;
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (rd_cnt_d == count_q) state_d = CHECK;
        end
      end

      CHECK: begin
        state_d = (rd_sum_q == wr_sum_q) ? DONE : ERROR;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge tb_clk) begin
    if (rstb) begin
      state_q  <= IDLE;
      base_q   <= '0;
      count_q  <= '0;
      wr_cnt_q <= '0;
      rd_idx_q <= '0;
      rd_cnt_q <= '0;
      rd_vld_q <= 1'b0;
      rd_sum_q <= '0;
      wr_sum_q <= '0;
      enb_q    <= 1'b0;
      web_q    <= 4'h0;
      addr_q   <= '0;
      din_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      hold_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      count_q  <= count_d;
      wr_cnt_q <= wr_cnt_d;
      rd_idx_q <= rd_idx_d;
      rd_cnt_q <= rd_cnt_d;
      rd_vld_q <= rd_vld_d;
      rd_sum_q <= rd_sum_d;
      wr_sum_q <= wr_sum_d;
      enb_q    <= enb_d;
      web_q    <= web_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      done_q   <= done_d;
      err_q    <= err_d;
      hold_q   <= hold_d;
    end
  end

  assign bus.s_ready    = s_ready_c;
  assign bus.bram_enb   = enb_q;
  assign bus.bram_web   = web_q;
  assign bus.bram_addrb = addr_q;
  assign bus.bram_dinb  = din_q;
  assign load_done      = done_q;
  assign load_error     = err_q;
  assign words_written  = wr_cnt_q;
  assign checksum       = wr_sum_q;
  assign core_hold      = hold_q;

endmodule

// File: tb/tb_ins_mem_loader.sv
// Randomized scoreboard bench for ins_mem_loader with a behavioural BRAM model.
// Expected BRAM accesses and load outcomes are queued at stimulus time and popped by monitors.
module tb_ins_mem_loader;

  localparam int CNT_W  = 16;
  localparam int ADDR_W = 32;

  logic              tb_clk;
  logic              rstb;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_count;
  logic              load_done;
  logic              load_error;
  logic [CNT_W-1:0]  words_written;
  logic [31:0]       checksum;
  logic              core_hold;

  ins_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  ins_mem_loader #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .tb_clk        (tb_clk),
    .rstb          (rstb),
    .start         (start),
    .base_addr     (base_addr),
    .word_count    (word_count),
    .bus           (bus),
    .load_done     (load_done),
    .load_error    (load_error),
    .words_written (words_written),
    .checksum      (checksum),
    .core_hold     (core_hold)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  typedef struct {
    bit          err;
    logic [31:0] sum;
    int          n;
  } res_t;

  acc_t        acc_q[$];
  res_t        res_q[$];
  logic [31:0] words[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int corrupt_at = -1;
  bit busy_en  = 1'b0;
  bit busy_at_edge = 1'b0;

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;
  always @(posedge tb_clk) cyc <= cyc + 1;
  always @(posedge tb_clk) busy_at_edge <= bus.bram_busy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural BRAM: registered read, byte-enabled write; reads counted per load so
  // one chosen readback can be corrupted.
  logic [31:0] mem [int unsigned];
  logic [31:0] dout_r = '0;
  logic [31:0] rd_val;
  int          rd_seq = 0;

  always @(posedge tb_clk) begin
    if (bus.bram_enb) begin
      if (bus.bram_web != 4'h0) begin
        rd_val = mem.exists(bus.bram_addrb >> 2) ? mem[bus.bram_addrb >> 2] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (bus.bram_web[b]) rd_val[8*b +: 8] = bus.bram_dinb[8*b +: 8];
        mem[bus.bram_addrb >> 2] = rd_val;
        rd_seq <= 0;
      end else begin
        rd_val = mem.exists(bus.bram_addrb >> 2) ? mem[bus.bram_addrb >> 2] : 32'h0;
        if (rd_seq == corrupt_at) rd_val = rd_val ^ 32'h1;
        dout_r <= rd_val;
        rd_seq <= rd_seq + 1;
      end
    end
  end
  assign bus.bram_doutb = dout_r;

  // Busy bursts of three cycles at random points while enabled.
  initial begin
    int left = 0;
    bus.bram_busy = 1'b0;
    forever begin
      @(negedge tb_clk);
      if (left > 0) left--;
      else if (busy_en && $urandom_range(0, 3) == 0) left = 3;
      bus.bram_busy = (left > 0);
    end
  end

  // Access monitor: every enabled BRAM cycle must match the next expected access.
  acc_t exp_a;
  always @(negedge tb_clk) begin
    if (bus.bram_enb) begin
      check("access_not_while_busy", 64'(busy_at_edge), 64'd0);
      check("access_expected", 64'(acc_q.size() != 0), 64'd1);
      if (acc_q.size() != 0) begin
        exp_a = acc_q.pop_front();
        check("access_web", 64'(bus.bram_web), exp_a.wr ? 64'hF : 64'h0);
        check("access_addr", 64'(bus.bram_addrb), 64'(exp_a.addr));
        if (exp_a.wr) check("access_din", 64'(bus.bram_dinb), 64'(exp_a.data));
      end
    end
  end

  // Outcome monitor: fires when load_done or load_error first rises.
  res_t exp_r;
  bit   fin_prev = 1'b0;
  always @(negedge tb_clk) begin
    if ((load_done || load_error) && !fin_prev) begin
      check("result_expected", 64'(res_q.size() != 0), 64'd1);
      if (res_q.size() != 0) begin
        exp_r = res_q.pop_front();
        check("result_done", 64'(load_done), exp_r.err ? 64'd0 : 64'd1);
        check("result_error", 64'(load_error), exp_r.err ? 64'd1 : 64'd0);
        check("result_core_hold", 64'(core_hold), exp_r.err ? 64'd1 : 64'd0);
        check("result_checksum", 64'(checksum), 64'(exp_r.sum));
        check("result_words_written", 64'(words_written), 64'(exp_r.n));
      end
    end
    fin_prev = load_done || load_error;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 64'(bus.s_ready), 64'd0);
    check({tag, "_enb"}, 64'(bus.bram_enb), 64'd0);
    check({tag, "_web"}, 64'(bus.bram_web), 64'd0);
    check({tag, "_addrb"}, 64'(bus.bram_addrb), 64'd0);
    check({tag, "_dinb"}, 64'(bus.bram_dinb), 64'd0);
    check({tag, "_load_done"}, 64'(load_done), 64'd0);
    check({tag, "_load_error"}, 64'(load_error), 64'd0);
    check({tag, "_words_written"}, 64'(words_written), 64'd0);
    check({tag, "_checksum"}, 64'(checksum), 64'd0);
    check({tag, "_core_hold"}, 64'(core_hold), 64'd1);
  endtask

  // Presents words[0..n_send-1]; gap<0 gives random idle cycles between words.
  task automatic stream_words(input int n_send, input int gap);
    int i = 0;
    int idle = 0;
    int guard = 0;
    while (i < n_send && guard < 4000) begin
      if (idle > 0) begin
        bus.s_valid = 1'b0;
        idle--;
      end else begin
        bus.s_valid = 1'b1;
        bus.s_data  = words[i];
        #4;
        if (bus.s_ready) begin
          i++;
          idle = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        end
      end
      @(negedge tb_clk);
      guard++;
    end
    bus.s_valid = 1'b0;
    check("stream_words_accepted", 64'(i), 64'(n_send));
  endtask

  task automatic stray_start_in_load();
    repeat (2) @(negedge tb_clk);
    start      = 1'b1;
    base_addr  = $urandom;
    word_count = CNT_W'($urandom_range(1, 40));
    @(negedge tb_clk);
    start = 1'b0;
  endtask

  // One complete load: queue the expected accesses/outcome, then drive it.
  task automatic run_load(input logic [31:0] base, input int n, input int gap,
                          input bit busy_on, input int corrupt, input bit stray,
                          input int abort_after);
    logic [31:0] b_eff;
    logic [31:0] sum;
    int          n_send;
    int          t0;
    int          limit;
    bit          aborted;
    aborted = (abort_after >= 0);
    n_send  = aborted ? abort_after : n;
    while (words.size() < n) words.push_back($urandom);
    b_eff = base & 32'hFFFF_FFFC;
    sum   = 32'h0;
    for (int i = 0; i < n; i++) sum = sum + words[i];
    for (int i = 0; i < n_send; i++)
      acc_q.push_back('{1'b1, b_eff + (32'(i) << 2), words[i]});
    if (!aborted) begin
      for (int i = 0; i < n; i++)
        acc_q.push_back('{1'b0, b_eff + (32'(i) << 2), 32'h0});
      res_q.push_back('{(corrupt >= 0 && corrupt < n), sum, n});
    end
    corrupt_at = corrupt;
    busy_en    = busy_on;

    @(negedge tb_clk);
    start      = 1'b1;
    base_addr  = base;
    word_count = CNT_W'(n);
    @(negedge tb_clk);
    start      = 1'b0;
    base_addr  = $urandom;
    word_count = CNT_W'($urandom);
    t0 = cyc;
    check("start_clears_done", 64'(load_done), 64'd0);
    check("start_clears_error", 64'(load_error), 64'd0);

    fork
      stream_words(n_send, gap);
      if (stray) stray_start_in_load();
    join

    if (aborted) begin
      rstb = 1'b1;
      @(negedge tb_clk);
      rstb = 1'b0;
      check_reset_outputs("abort");
      busy_en = 1'b0;
    end else begin
      if (stray) begin
        start     = 1'b1;
        base_addr = $urandom;
        @(negedge tb_clk);
        start = 1'b0;
      end
      limit = 8 * n + 100;
      while (!(load_done || load_error) && (cyc - t0) < limit) begin
        check("core_hold_during_load", 64'(core_hold), 64'd1);
        @(negedge tb_clk);
      end
      check("load_finished_in_time", 64'(load_done || load_error), 64'd1);
      if (gap == 0 && !busy_on)
        check("latency_within_2n_plus_4", 64'((cyc - t0) <= 2 * n + 4), 64'd1);
      busy_en = 1'b0;
      @(negedge tb_clk);
      check("result_outputs_sticky", 64'(load_done || load_error), 64'd1);
    end
    check("all_accesses_seen", 64'(acc_q.size()), 64'd0);
    check("all_results_seen", 64'(res_q.size()), 64'd0);
    corrupt_at = -1;
    words.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rbase;
    int          rn;
    int          rcor;
    rstb         = 1'b1;
    start        = 1'b0;
    base_addr    = '0;
    word_count   = '0;
    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    repeat (3) @(negedge tb_clk);
    rstb = 1'b0;
    check_reset_outputs("reset");

    // Stray stream traffic while idle must never be accepted.
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hCAFE_F00D;
    for (int i = 0; i < 4; i++) begin
      #4;
      check("idle_s_ready_low", 64'(bus.s_ready), 64'd0);
      @(negedge tb_clk);
    end
    bus.s_valid = 1'b0;

    // Nominal four-word program.
    words = '{32'h0000_0013, 32'h0050_0093, 32'h00A0_0113, 32'hDEAD_BEEF};
    run_load(32'h0000_0384, 4, 0, 1'b0, -1, 1'b0, -1);

    // Zero-length load completes without touching the BRAM.
    run_load(32'h0000_1000, 0, 0, 1'b0, -1, 1'b0, -1);

    // Gaps in the stream and BRAM busy stalls.
    run_load(32'h0000_2000, 3, 2, 1'b1, -1, 1'b0, -1);

    // Second readback corrupted; the following load clears the error.
    run_load(32'h0000_3000, 2, 0, 1'b0, 1, 1'b0, -1);

    // Reset after two of five words, then a clean five-word load.
    run_load(32'h0000_4000, 5, 0, 1'b0, -1, 1'b0, 2);
    run_load(32'h0000_4000, 5, 0, 1'b0, -1, 1'b0, -1);

    // Start pulses during LOAD and VERIFY are ignored.
    run_load(32'h0000_5002, 6, 0, 1'b0, -1, 1'b1, -1);

    // Address wrap at the top of the space, low base bits ignored.
    run_load(32'hFFFF_FFF7, 4, 0, 1'b0, -1, 1'b0, -1);

    // Randomized loads.
    for (int k = 0; k < 10; k++) begin
      rbase = $urandom;
      rn    = int'($urandom_range(0, 10));
      rcor  = (rn > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, rn - 1)) : -1;
      run_load(rbase, rn, ($urandom_range(0, 1) == 0) ? -1 : 0,
               1'($urandom_range(0, 1)), rcor, 1'b0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
